// File: rtl/sample_sequencer_pkg.sv
// Shared types and helpers for the sample sequencer slice.
// Optional statistics counters are enabled by defining SEQ_STATS_EN.
package seq_pkg;

    localparam int unsigned NCH      = 4;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned FRAME_W  = NCH * SAMPLE_W;
    localparam int unsigned STAT_W   = 16;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, CAPTURE} seq_state_t;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Channel 0 sits in the MSBs of every sample bus.
    typedef struct packed {
        sample_t ch0;
        sample_t ch1;
        sample_t ch2;
        sample_t ch3;
    } frame_t;

    function automatic frame_t sample_pack(input sample_t c0, input sample_t c1,
                                           input sample_t c2, input sample_t c3);
        frame_t f;
        f.ch0 = c0;
        f.ch1 = c1;
        f.ch2 = c2;
        f.ch3 = c3;
        return f;
    endfunction

    function automatic sample_t sample_unpack(input frame_t f, input logic [1:0] ch);
        case (ch)
            2'd0:    return f.ch0;
            2'd1:    return f.ch1;
            2'd2:    return f.ch2;
            default: return f.ch3;
        endcase
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/sample_sequencer_if.sv
// Sample, network and DAC stream signals of the sequencer; master is the sequencer side.
// Statistics counters exist only when SEQ_STATS_EN is defined.
interface sample_sequencer_if #(
    parameter int unsigned W = 16
);
    localparam int unsigned BUS_W = seq_pkg::NCH * W;

    logic [BUS_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] net_sample;
    logic             net_start;
    logic             net_done;
    logic [BUS_W-1:0] net_out;
    logic [BUS_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             underrun;
    logic             overrun;
    logic             timeout;
    logic             clr_flags;
`ifdef SEQ_STATS_EN
    logic [seq_pkg::STAT_W-1:0] underrun_cnt;
    logic [seq_pkg::STAT_W-1:0] overrun_cnt;
    logic [seq_pkg::STAT_W-1:0] timeout_cnt;
`endif

    modport master (
        input  in_data, in_valid, net_done, net_out, out_ready, clr_flags,
        output in_ready, net_sample, net_start, out_data, out_valid, underrun, overrun, timeout
`ifdef SEQ_STATS_EN
        , output underrun_cnt, overrun_cnt, timeout_cnt
`endif
    );

    modport slave (
        output in_data, in_valid, net_done, net_out, out_ready, clr_flags,
        input  in_ready, net_sample, net_start, out_data, out_valid, underrun, overrun, timeout
`ifdef SEQ_STATS_EN
        , input underrun_cnt, overrun_cnt, timeout_cnt
`endif
    );

endinterface

// File: rtl/sample_sequencer_tick_gen.sv
// Sample-rate divider: counts 0..PERIOD-1 and flags the last count as the tick.
module sample_tick_gen #(
    parameter int unsigned PERIOD = 256
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_c
);
    localparam int unsigned CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sample_sequencer.sv
// Feeds one sample set per tick to the network, waits for its result and offers it downstream.
// Define SEQ_STATS_EN to add saturating underrun/overrun/timeout event counters.
module sample_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned PERIOD  = 256,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    sample_sequencer_if.master bus
);
    localparam int unsigned BUS_W  = NCH * W;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    seq_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [BUS_W-1:0]  sample_q;
    logic [BUS_W-1:0]  out_q;
    logic              start_q;
    logic              valid_q;
    logic              under_q;
    logic              over_q;
    logic              tmo_q;
    logic              tick_c;
    logic              set_under_c;
    logic              set_over_c;
    logic              set_tmo_c;

    sample_tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_c (tick_c)
    );

    assign bus.in_ready   = (state == IDLE) && tick_c;
    assign bus.net_sample = sample_q;
    assign bus.net_start  = start_q;
    assign bus.out_data   = out_q;
    assign bus.out_valid  = valid_q;
    assign bus.underrun   = under_q;
    assign bus.overrun    = over_q;
    assign bus.timeout    = tmo_q;

    // Flag-set events; net_done beats the timeout check in the same cycle.
    always_comb begin
        set_under_c = 1'b0;
        set_over_c  = 1'b0;
        set_tmo_c   = 1'b0;
        if (tick_c && (state == IDLE) && !bus.in_valid) set_under_c = 1'b1;
        if (tick_c && (state != IDLE)) set_over_c = 1'b1;
        if ((state == WAIT) && bus.net_done && valid_q && !bus.out_ready) set_over_c = 1'b1;
        if ((state == WAIT) && !bus.net_done && (wait_cnt == WAIT_W'(TIMEOUT - 1))) set_tmo_c = 1'b1;
    end

    // net_out is captured on the net_done edge so out_valid follows done by one cycle;
    // CAPTURE is the settle cycle before IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            sample_q <= '0;
            out_q    <= '0;
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
            under_q  <= 1'b0;
            over_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (valid_q && bus.out_ready) valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_c) begin
                        if (bus.in_valid) sample_q <= bus.in_data;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    start_q  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.net_done) begin
                        out_q   <= bus.net_out;
                        valid_q <= 1'b1;
                        state   <= CAPTURE;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (bus.clr_flags) begin
                under_q <= 1'b0;
                over_q  <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                if (set_under_c) under_q <= 1'b1;
                if (set_over_c)  over_q  <= 1'b1;
                if (set_tmo_c)   tmo_q   <= 1'b1;
            end
        end
    end

`ifdef SEQ_STATS_EN
    logic [STAT_W-1:0] under_cnt_q;
    logic [STAT_W-1:0] over_cnt_q;
    logic [STAT_W-1:0] tmo_cnt_q;

    assign bus.underrun_cnt = under_cnt_q;
    assign bus.overrun_cnt  = over_cnt_q;
    assign bus.timeout_cnt  = tmo_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            under_cnt_q <= '0;
            over_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
        end else if (bus.clr_flags) begin
            under_cnt_q <= '0;
            over_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            if (set_under_c) under_cnt_q <= sat_inc(under_cnt_q);
            if (set_over_c)  over_cnt_q  <= sat_inc(over_cnt_q);
            if (set_tmo_c)   tmo_cnt_q   <= sat_inc(tmo_cnt_q);
        end
    end
`endif

endmodule

// File: tb/tb_sample_sequencer.sv
// Randomized self-checking bench for sample_sequencer against a transaction-level model.
module tb_sample_sequencer;
    import seq_pkg::*;

    localparam int unsigned W       = 16;
    localparam int unsigned PERIOD  = 16;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned BUS_W   = NCH * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sample_sequencer_if #(.W(W)) bus ();

    sample_sequencer #(.W(W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: last launched sample set, pending DAC word and sticky flags.
    logic [BUS_W-1:0] m_sample;
    logic [BUS_W-1:0] m_out;
    logic             m_ov;
    logic             m_under, m_over, m_tmo;
    logic [15:0]      m_under_n, m_over_n, m_tmo_n;
    longint           cyc;
    longint           last_tick;
    bit               tick_known;

    function automatic logic [BUS_W-1:0] rnd_frame();
        return sample_pack(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endfunction

    task automatic model_reset();
        m_sample = '0; m_out = '0; m_ov = 1'b0;
        m_under = 1'b0; m_over = 1'b0; m_tmo = 1'b0;
        m_under_n = '0; m_over_n = '0; m_tmo_n = '0;
        tick_known = 1'b0;
    endtask

    // One clock; a pending DAC word is taken whenever out_ready is high at the edge.
    task automatic step();
        if (bus.out_ready) m_ov = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    // rdy: 0 = never ready, 1 = always ready, 2 = ready only in the net_done cycle.
    task automatic do_pass(input bit valid, input int delay, input int rdy, input string tag);
        bit found = 1'b0;
        logic [BUS_W-1:0] d;
        bus.in_valid  = valid;
        bus.out_ready = (rdy == 1);
        bus.in_data   = rnd_frame();
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (bus.in_ready === 1'b1) begin found = 1'b1; break; end
            step();
        end
        n_chk++;
        if (!found) begin
            $display("FAIL %s.tick_wait got=no in_ready exp=in_ready within %0d cycles", tag, 3 * PERIOD);
            return;
        end else n_pass++;
        if (tick_known) begin
            n_chk++;
            if ((cyc - last_tick) % PERIOD != 0)
                $display("FAIL %s.tick_period got=%0d exp=multiple of %0d", tag, cyc - last_tick, PERIOD);
            else n_pass++;
        end
        last_tick = cyc; tick_known = 1'b1;
        if (valid) m_sample = bus.in_data;
        else begin m_under = 1'b1; m_under_n++; end
        step();
        bus.in_data = rnd_frame();
        n_chk++;
        if (bus.net_start !== 1'b0) $display("FAIL %s.start_early got=%b exp=0", tag, bus.net_start);
        else n_pass++;
        step();
        n_chk++;
        if (bus.net_start !== 1'b1) $display("FAIL %s.start_latency got=%b exp=1", tag, bus.net_start);
        else n_pass++;
        n_chk++;
        if (bus.net_sample !== m_sample) $display("FAIL %s.net_sample got=%h exp=%h", tag, bus.net_sample, m_sample);
        else n_pass++;
        step();
        n_chk++;
        if (bus.net_start !== 1'b0) $display("FAIL %s.start_width got=%b exp=0", tag, bus.net_start);
        else n_pass++;
        if (delay > 0) begin
            for (int i = 1; i < delay; i++) step();
            bus.net_done = 1'b1;
            bus.net_out  = rnd_frame();
            d = bus.net_out;
            if (rdy == 2) bus.out_ready = 1'b1;
            if (m_ov && !bus.out_ready) begin m_over = 1'b1; m_over_n++; end
            step();
            bus.net_done  = 1'b0;
            bus.net_out   = rnd_frame();
            bus.out_ready = (rdy == 1);
            m_ov = 1'b1; m_out = d;
            n_chk++;
            if (bus.out_valid !== 1'b1) $display("FAIL %s.out_valid_lat got=%b exp=1", tag, bus.out_valid);
            else n_pass++;
            n_chk++;
            if (bus.out_data !== m_out) $display("FAIL %s.out_data got=%h exp=%h", tag, bus.out_data, m_out);
            else n_pass++;
        end else begin
            for (int i = 1; i < TIMEOUT - 1; i++) step();
            n_chk++;
            if (bus.timeout !== m_tmo) $display("FAIL %s.timeout_early got=%b exp=%b", tag, bus.timeout, m_tmo);
            else n_pass++;
            step();
            m_tmo = 1'b1; m_tmo_n++;
            n_chk++;
            if (bus.timeout !== 1'b1) $display("FAIL %s.timeout_set got=%b exp=1", tag, bus.timeout);
            else n_pass++;
            n_chk++;
            if (bus.out_valid !== m_ov) $display("FAIL %s.out_valid_hold got=%b exp=%b", tag, bus.out_valid, m_ov);
            else n_pass++;
        end
        n_chk++;
        if ({bus.underrun, bus.overrun, bus.timeout} !== {m_under, m_over, m_tmo})
            $display("FAIL %s.flags got=%b%b%b exp=%b%b%b", tag, bus.underrun, bus.overrun, bus.timeout,
                     m_under, m_over, m_tmo);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = rnd_frame();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.in_ready, bus.net_start, bus.out_valid, bus.underrun, bus.overrun, bus.timeout} !== 6'b0)
            $display("FAIL reset.ctrl got=%b exp=000000",
                     {bus.in_ready, bus.net_start, bus.out_valid, bus.underrun, bus.overrun, bus.timeout});
        else n_pass++;
        n_chk++;
        if ({bus.net_sample, bus.out_data} !== '0)
            $display("FAIL reset.data got=%h/%h exp=0/0", bus.net_sample, bus.out_data);
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_nominal();
        for (int i = 0; i < 4; i++) do_pass(1'b1, 3, 1, "nominal");
    endtask

    task automatic test_underrun();
        do_pass(1'b0, 3, 1, "underrun");
    endtask

    task automatic test_timeout();
        do_pass(1'b1, -1, 1, "timeout");
        do_pass(1'b1, 2, 1, "after_timeout");
    endtask

    task automatic test_done_at_limit();
        do_pass(1'b1, TIMEOUT - 1, 1, "done_at_limit");
    endtask

    task automatic test_overrun();
        do_pass(1'b1, 3, 0, "overrun_a");
        do_pass(1'b1, 4, 0, "overrun_b");
    endtask

    task automatic test_capture_accept();
        do_pass(1'b1, 3, 2, "capture_accept");
    endtask

    task automatic test_clr_flags();
`ifdef SEQ_STATS_EN
        n_chk++;
        if ({bus.underrun_cnt, bus.overrun_cnt, bus.timeout_cnt} !== {m_under_n, m_over_n, m_tmo_n})
            $display("FAIL stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.underrun_cnt, bus.overrun_cnt,
                     bus.timeout_cnt, m_under_n, m_over_n, m_tmo_n);
        else n_pass++;
`endif
        bus.clr_flags = 1'b1;
        step();
        bus.clr_flags = 1'b0;
        m_under = 1'b0; m_over = 1'b0; m_tmo = 1'b0;
        m_under_n = '0; m_over_n = '0; m_tmo_n = '0;
        n_chk++;
        if ({bus.underrun, bus.overrun, bus.timeout} !== 3'b000)
            $display("FAIL clr_flags got=%b%b%b exp=000", bus.underrun, bus.overrun, bus.timeout);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int dl = $urandom_range(0, TIMEOUT - 1);
            do_pass($urandom_range(0, 3) != 0, (dl == 0) ? -1 : dl, $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_reset_mid_pass();
        bit found = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = rnd_frame();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (bus.in_ready === 1'b1) begin found = 1'b1; break; end
            step();
        end
        n_chk++;
        if (!found) $display("FAIL rst_mid.tick_wait got=no in_ready exp=in_ready");
        else n_pass++;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.net_start, bus.out_valid, bus.underrun, bus.overrun, bus.timeout} !== 5'b0 ||
            {bus.net_sample, bus.out_data} !== '0)
            $display("FAIL rst_mid.async got=%b%b%b%b%b %h/%h exp=00000 0/0", bus.net_start, bus.out_valid,
                     bus.underrun, bus.overrun, bus.timeout, bus.net_sample, bus.out_data);
        else n_pass++;
        step();
        rst_n = 1'b1;
        model_reset();
        bus.net_done = 1'b1;
        bus.net_out  = rnd_frame();
        step();
        bus.net_done = 1'b0;
        step();
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0)
            $display("FAIL rst_mid.stray_done got=%b/%h exp=0/0", bus.out_valid, bus.out_data);
        else n_pass++;
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.net_done  = 1'b0;
        bus.net_out   = '0;
        bus.out_ready = 1'b0;
        bus.clr_flags = 1'b0;
        cyc = 0;
        last_tick = 0;
        model_reset();
        test_reset();
        test_nominal();
        test_underrun();
        test_timeout();
        test_clr_flags();
        test_done_at_limit();
        test_overrun();
        test_capture_accept();
        test_clr_flags();
        test_random();
        test_clr_flags();
        test_reset_mid_pass();
        do_pass(1'b0, -1, 1, "post_reset");
        test_clr_flags();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
